saturn_debug_sequencer: RTL and testbench
=========================================

Name: saturn_debug_sequencer

Overview:
Schedules debugger windows for the Saturn core. It decides, per decoded instruction, whether to open a debug window, using one of four modes: off, trace-all, PC breakpoint or single-step. While a window is open it stalls the core, walks a register-dump index across the register file with a valid/ready handshake to the dump sink, and then releases the core. It sits between the control unit (phase/decode signals), the phase generator (stall) and the register-file dump port.

Parameters:
NUM_REGS, 16, number of dump slots per window (2..16); o_reg_sel counts 0..NUM_REGS-1
PC_WIDTH, 20, width of program counter and breakpoint address

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_phases  in  4  one-hot phase strobes from the phase generator
i_instr_decoded  in  1  control unit: instruction decode complete
i_pc  in  PC_WIDTH  address of the decoded instruction
i_mode  in  2  0=off, 1=trace-all, 2=breakpoint, 3=single-step
i_bp_addr  in  PC_WIDTH  breakpoint address, used in mode 2
i_step_go  in  1  single-cycle pulse that releases a single-step window
i_dump_ready  in  1  dump sink accepts the current slot
o_debug_cycle  out  1  a debug window is open
o_stall  out  1  freezes the phase generator
o_reg_sel  out  4  register slot being dumped
o_dump_valid  out  1  o_reg_sel is presented to the sink
o_hit_count  out  16  number of windows entered

Behaviour:
- Reset: state=IDLE, o_debug_cycle=0, o_stall=0, o_reg_sel=0, o_dump_valid=0, o_hit_count=0, armed=1. Reset wins over every other event. Reset mid-window aborts the window; reset values are visible after the clock edge.
- All outputs are registered. A trigger sampled at edge T gives o_debug_cycle=o_stall=o_dump_valid=1 and o_reg_sel=0 after edge T.
- Trigger, evaluated only in IDLE: armed && i_phases[3] && i_instr_decoded && cond.
  - cond is true for mode 1 and mode 3.
  - cond is true for mode 2 only when i_pc==i_bp_addr (full-width compare).
  - cond is false for mode 0.
- On trigger: latch i_mode into mode_q; o_hit_count increments, wrapping 0xFFFF->0x0000; armed clears.
- States:
  - IDLE: waits for a trigger, then goes to DUMP.
  - DUMP: o_dump_valid=1. A handshake is o_dump_valid && i_dump_ready.
    - Handshake with o_reg_sel<NUM_REGS-1: o_reg_sel increments.
    - Handshake with o_reg_sel==NUM_REGS-1: o_dump_valid drops; go to WAIT_STEP if mode_q==3, else RELEASE.
    - i_dump_ready low: o_reg_sel and o_dump_valid hold, with no timeout.
  - WAIT_STEP: o_stall=1, o_debug_cycle=1, o_dump_valid=0. An i_step_go pulse moves the block to RELEASE.
  - RELEASE: lasts one cycle with o_debug_cycle=0, o_stall=0, o_reg_sel=0; then IDLE.
- Rearm: armed sets on any cycle in which state is IDLE or RELEASE and i_phases[3]=0. This prevents the same stalled phase-3 strobe from retriggering.
- Mode is latched per window. A change to i_mode during a window (including to 0) affects only the next trigger; the current window completes normally.
- i_step_go outside WAIT_STEP is ignored, including when it coincides with the final DUMP handshake.
- Window length with i_dump_ready held high: NUM_REGS cycles with o_stall=1 (trace or breakpoint), then one RELEASE cycle.
- Invariant: o_dump_valid=1 implies o_stall=1 and o_debug_cycle=1.

Test Plan:
- Mode 1, i_dump_ready=1, i_phases[3] and i_instr_decoded pulsed at cycle 10:
  - cycles 11..26: o_stall=1, o_reg_sel steps 0..15;
  - cycle 27: all low;
  - o_hit_count=1.
- Mode 2, i_bp_addr=0x0A3C0, decodes at i_pc=0x0A3BF then 0x0A3C0 -> no window for the first, one window for the second; o_hit_count=1.
- Mode 3, i_step_go pulsed at cycles 5, 30 and 40 after trigger:
  - the pulse at 5 (still in DUMP) is ignored;
  - the block holds in WAIT_STEP with o_stall=1 and o_dump_valid=0;
  - release follows the pulse at 30; the pulse at 40 has no effect.
- Backpressure: i_dump_ready low for 5 cycles at o_reg_sel=3 -> o_reg_sel stays 3 and o_dump_valid stays 1 for 5 cycles, then resumes at 4; the window is 5 cycles longer.
- Rearm: i_phases[3] and i_instr_decoded held high through the whole window in mode 1 -> exactly one window; a second window opens only after i_phases[3] drops and rises again.
- i_reset asserted at o_reg_sel=7 -> next cycle all outputs 0 and o_hit_count=0; a trigger in the cycle after reset releases opens a fresh window.

Source files
------------

// File: rtl/saturn_debug_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : saturn_debug_sequencer
// Purpose  : Opens debugger windows on decoded instructions (off / trace-all /
//            PC breakpoint / single-step). While a window is open the core
//            is stalled and the register file is dumped slot by slot through
//            a valid/ready handshake, then the core is released.
// Revision : 1.0 - initial release
// ============================================================================
module saturn_debug_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int PC_WIDTH = 20
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [3:0]          i_phases,
  input  logic                i_instr_decoded,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic [1:0]          i_mode,
  input  logic [PC_WIDTH-1:0] i_bp_addr,
  input  logic                i_step_go,
  input  logic                i_dump_ready,
  output logic                o_debug_cycle,
  output logic                o_stall,
  output logic [3:0]          o_reg_sel,
  output logic                o_dump_valid,
  output logic [15:0]         o_hit_count
);

  localparam logic [3:0] LAST_SEL  = 4'(NUM_REGS - 1);
  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ALL  = 2'd1;
  localparam logic [1:0] MODE_BP   = 2'd2;
  localparam logic [1:0] MODE_STEP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DUMP      = 2'd1,
    ST_WAIT_STEP = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic        armed_q, armed_d;
  logic        debug_q, debug_d;
  logic        stall_q, stall_d;
  logic        valid_q, valid_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] hits_q, hits_d;

  logic        cond;
  logic        trigger;
  logic        rearm;

  // Only the phase-3 strobe matters here; the other phases are don't-care.
  logic        unused_phases;
  assign unused_phases = ^i_phases[2:0];

  // Trigger qualification for the currently selected mode.
  always_comb begin
    cond = 1'b0;
    case (i_mode)
      MODE_ALL, MODE_STEP: cond = 1'b1;
      MODE_BP:             cond = (i_pc == i_bp_addr);
      MODE_OFF:            cond = 1'b0;
      default:             cond = 1'b0;
    endcase
    trigger = (state_q == ST_IDLE) && armed_q && i_phases[3] && i_instr_decoded && cond;
    // A stalled phase-3 strobe stays high; rearming only after it drops stops
    // the same instruction from opening a second window.
    rearm   = ((state_q == ST_IDLE) || (state_q == ST_RELEASE)) && !i_phases[3];
  end

  // Next-state and next-output computation for the window sequencer.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    debug_d = debug_q;
    stall_d = stall_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    hits_d  = hits_q;

    if (rearm) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_DUMP;
          mode_d  = i_mode;
          armed_d = 1'b0;
          hits_d  = hits_q + 16'd1;
          debug_d = 1'b1;
          stall_d = 1'b1;
          valid_d = 1'b1;
          sel_d   = 4'd0;
        end
      end
      ST_DUMP: begin
        if (i_dump_ready) begin
          if (sel_q == LAST_SEL) begin
            valid_d = 1'b0;
            if (mode_q == MODE_STEP) begin
              // Core stays frozen until the debugger steps it.
              state_d = ST_WAIT_STEP;
            end else begin
              state_d = ST_RELEASE;
              debug_d = 1'b0;
              stall_d = 1'b0;
              sel_d   = 4'd0;
            end
          end else begin
            sel_d = sel_q + 4'd1;
          end
        end
      end
      ST_WAIT_STEP: begin
        if (i_step_go) begin
          state_d = ST_RELEASE;
          debug_d = 1'b0;
          stall_d = 1'b0;
          sel_d   = 4'd0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any open window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      armed_q <= 1'b1;
      debug_q <= 1'b0;
      stall_q <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= 4'd0;
      hits_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
      debug_q <= debug_d;
      stall_q <= stall_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      hits_q  <= hits_d;
    end
  end

  assign o_debug_cycle = debug_q;
  assign o_stall       = stall_q;
  assign o_dump_valid  = valid_q;
  assign o_reg_sel     = sel_q;
  assign o_hit_count   = hits_q;

endmodule
`default_nettype wire

// File: tb/tb_saturn_debug_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_saturn_debug_sequencer
// Purpose  : Self-checking bench: directed vector table, hand-written window
//            sequences and randomized traffic against a window-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saturn_debug_sequencer;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ph;
  logic        dec;
  logic [19:0] pc;
  logic [1:0]  mode;
  logic [19:0] bp;
  logic        step;
  logic        ready;
  logic        o_debug_cycle, o_stall, o_dump_valid;
  logic [3:0]  o_reg_sel;
  logic [15:0] o_hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  saturn_debug_sequencer #(.NUM_REGS(NR), .PC_WIDTH(20)) dut (
    .i_clk(clk), .i_reset(rst), .i_phases(ph), .i_instr_decoded(dec),
    .i_pc(pc), .i_mode(mode), .i_bp_addr(bp), .i_step_go(step),
    .i_dump_ready(ready), .o_debug_cycle(o_debug_cycle), .o_stall(o_stall),
    .o_reg_sel(o_reg_sel), .o_dump_valid(o_dump_valid), .o_hit_count(o_hit_count)
  );

  // Window-level reference: a window is "dumping slot N", "waiting for step"
  // or "releasing"; anything else is idle.
  bit         m_dump, m_wait, m_rel, m_armed;
  int         m_slot, m_hits;
  logic [1:0] m_wmode;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit idle, rearm, cond;
    if (rst) begin
      m_dump = 0; m_wait = 0; m_rel = 0; m_armed = 1; m_slot = 0; m_hits = 0;
      return;
    end
    idle  = !(m_dump || m_wait || m_rel);
    rearm = (idle || m_rel) && !ph[3];
    cond  = (mode == 2'd1) || (mode == 2'd3) || (mode == 2'd2 && pc == bp);
    if (idle) begin
      if (m_armed && ph[3] && dec && cond) begin
        m_dump = 1; m_slot = 0; m_hits = (m_hits + 1) % 65536;
        m_wmode = mode; m_armed = 0;
      end
    end else if (m_dump) begin
      if (ready) begin
        if (m_slot == NR - 1) begin
          m_dump = 0;
          if (m_wmode == 2'd3) m_wait = 1; else m_rel = 1;
        end else begin
          m_slot++;
        end
      end
    end else if (m_wait) begin
      if (step) begin m_wait = 0; m_rel = 1; end
    end else begin
      m_rel = 0;
    end
    if (rearm) m_armed = 1;
  endtask

  // One clock: advance the model on the edge, then compare away from it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_debug", o_debug_cycle, int'(m_dump || m_wait));
    chk("m_stall", o_stall, int'(m_dump || m_wait));
    chk("m_valid", o_dump_valid, int'(m_dump));
    if (!m_wait) chk("m_sel", o_reg_sel, m_dump ? m_slot : 0);
    chk("m_hits", o_hit_count, m_hits);
    chk("m_invariant", int'(o_dump_valid && !(o_stall && o_debug_cycle)), 0);
  endtask

  task automatic idle_in();
    rst = 0; ph = 4'b0001; dec = 0; step = 0; ready = 1;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; tick(); rst = 0;
  endtask

  task automatic pulse();
    ph = 4'b1000; dec = 1; tick(); ph = 4'b0001; dec = 0;
  endtask

  task automatic finish_window(input string name);
    int g;
    for (g = 0; g < 200 && o_debug_cycle; g++) begin
      step = 1; tick();
    end
    step = 0;
    if (g >= 200) chk({name, "_timeout"}, 1, 0);
    tick();
  endtask

  typedef struct {
    logic rst; logic [3:0] ph; logic dec; logic [1:0] mode;
    logic [19:0] pc; logic [19:0] bp; logic step; logic ready;
    logic dbg; logic stl; logic vld; logic [3:0] sel; logic [15:0] hits;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h0;
    // rst ph dec mode pc bp step ready | dbg stl vld sel hits
    tbl[0]  = '{1, 4'b0001, 0, 2'd0, 20'h0, 20'h0, 0, 1,  0, 0, 0, 4'd0, 16'd0};
    tbl[1]  = '{0, 4'b0001, 1, 2'd1, 20'h0, 20'h0, 0, 1,  0, 0, 0, 4'd0, 16'd0};
    tbl[2]  = '{0, 4'b1000, 1, 2'd0, 20'h0, 20'h0, 0, 1,  0, 0, 0, 4'd0, 16'd0};
    tbl[3]  = '{0, 4'b1000, 1, 2'd2, 20'h00100, 20'h00101, 0, 1,  0, 0, 0, 4'd0, 16'd0};
    tbl[4]  = '{0, 4'b1000, 0, 2'd1, 20'h0, 20'h0, 0, 1,  0, 0, 0, 4'd0, 16'd0};
    tbl[5]  = '{0, 4'b1000, 1, 2'd2, 20'h12345, 20'h12345, 0, 0,  1, 1, 1, 4'd0, 16'd1};
    tbl[6]  = '{0, 4'b0001, 0, 2'd2, 20'h0, 20'h0, 0, 0,  1, 1, 1, 4'd0, 16'd1};
    tbl[7]  = '{0, 4'b0001, 0, 2'd0, 20'h0, 20'h0, 0, 1,  1, 1, 1, 4'd1, 16'd1};
    tbl[8]  = '{0, 4'b0001, 0, 2'd0, 20'h0, 20'h0, 1, 1,  1, 1, 1, 4'd2, 16'd1};
    tbl[9]  = '{1, 4'b0001, 0, 2'd0, 20'h0, 20'h0, 0, 1,  0, 0, 0, 4'd0, 16'd0};
    tbl[10] = '{0, 4'b1000, 1, 2'd3, 20'h0, 20'h0, 0, 1,  1, 1, 1, 4'd0, 16'd1};
    tbl[11] = '{0, 4'b1000, 1, 2'd3, 20'h0, 20'h0, 0, 1,  1, 1, 1, 4'd1, 16'd1};
    tbl[12] = '{1, 4'b0001, 0, 2'd0, 20'h0, 20'h0, 0, 1,  0, 0, 0, 4'd0, 16'd0};

    idle_in(); mode = 0; pc = 0; bp = 0;
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; ph = tbl[i].ph; dec = tbl[i].dec; mode = tbl[i].mode;
      pc = tbl[i].pc; bp = tbl[i].bp; step = tbl[i].step; ready = tbl[i].ready;
      tick();
      chk("tbl_debug", o_debug_cycle, tbl[i].dbg);
      chk("tbl_stall", o_stall, tbl[i].stl);
      chk("tbl_valid", o_dump_valid, tbl[i].vld);
      chk("tbl_sel", o_reg_sel, tbl[i].sel);
      chk("tbl_hits", o_hit_count, tbl[i].hits);
    end

    // Trace-all: 16 stalled dump cycles, then everything low.
    do_reset(); mode = 1; tick();
    pulse();
    for (int k = 0; k < NR; k++) begin
      chk("m1_stall", o_stall, 1);
      chk("m1_sel", o_reg_sel, k);
      tick();
    end
    chk("m1_end_debug", o_debug_cycle, 0);
    chk("m1_end_stall", o_stall, 0);
    chk("m1_end_valid", o_dump_valid, 0);
    chk("m1_hits", o_hit_count, 1);
    tick();

    // Breakpoint: one-below address misses, exact address hits.
    do_reset(); mode = 2; bp = 20'h0A3C0; pc = 20'h0A3BF;
    pulse();
    chk("m2_miss", o_debug_cycle, 0);
    tick();
    pc = 20'h0A3C0;
    pulse();
    chk("m2_hit", o_debug_cycle, 1);
    finish_window("m2");
    chk("m2_hits", o_hit_count, 1);

    // Single-step: early step ignored, mode change mid-window ignored.
    do_reset(); mode = 3;
    pulse();
    for (int c = 1; c <= 45; c++) begin
      step = (c == 5 || c == 30 || c == 40);
      if (c == 8) mode = 0;
      tick();
      step = 0;
      if (c <= 15) begin
        chk("m3_dump_valid", o_dump_valid, 1);
        chk("m3_dump_sel", o_reg_sel, c);
      end else if (c <= 29) begin
        chk("m3_wait_stall", o_stall, 1);
        chk("m3_wait_valid", o_dump_valid, 0);
      end else begin
        chk("m3_rel_stall", o_stall, 0);
        chk("m3_rel_debug", o_debug_cycle, 0);
      end
    end
    chk("m3_hits", o_hit_count, 1);

    // Backpressure at slot 3 stretches the window by 5 cycles.
    do_reset(); mode = 1;
    pulse(); n = 1;
    repeat (3) begin tick(); n++; end
    chk("bp_sel3", o_reg_sel, 3);
    ready = 0;
    repeat (5) begin
      tick(); n++;
      chk("bp_hold_sel", o_reg_sel, 3);
      chk("bp_hold_valid", o_dump_valid, 1);
    end
    ready = 1; tick(); n++;
    chk("bp_resume_sel", o_reg_sel, 4);
    for (int g = 0; g < 100 && o_stall; g++) begin
      tick();
      if (o_stall) n++;
    end
    chk("bp_window_len", n, NR + 5);

    // Rearm: strobe held high through the window gives exactly one window.
    do_reset(); mode = 1; ph = 4'b1000; dec = 1;
    repeat (40) tick();
    chk("rearm_single", o_hit_count, 1);
    chk("rearm_idle", o_debug_cycle, 0);
    ph = 4'b0001; tick();
    ph = 4'b1000; tick();
    chk("rearm_second", o_debug_cycle, 1);
    chk("rearm_hits", o_hit_count, 2);
    ph = 4'b0001; dec = 0;
    finish_window("rearm");

    // Reset mid-window, then immediate retrigger.
    do_reset(); mode = 1;
    pulse();
    repeat (7) tick();
    chk("rst_sel7", o_reg_sel, 7);
    rst = 1; tick(); rst = 0;
    chk("rst_debug", o_debug_cycle, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_dump_valid, 0);
    chk("rst_sel", o_reg_sel, 0);
    chk("rst_hits", o_hit_count, 0);
    ph = 4'b1000; dec = 1; tick();
    chk("rst_retrig", o_debug_cycle, 1);
    chk("rst_retrig_sel", o_reg_sel, 0);
    chk("rst_retrig_hits", o_hit_count, 1);
    ph = 4'b0001; dec = 0;
    finish_window("rst");

    // Randomized traffic against the model.
    do_reset(); h0 = 0;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ph    = 4'(1 << $urandom_range(0, 3));
      dec   = ($urandom_range(0, 3) != 0);
      mode  = 2'($urandom_range(0, 3));
      bp    = 20'($urandom);
      pc    = $urandom_range(0, 1) ? bp : 20'($urandom);
      step  = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 3) != 0);
      tick();
      if (o_hit_count > h0) h0 = o_hit_count;
    end
    chk("rnd_some_windows", int'(h0 > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
